param_counter: RTL and testbench

- Parametrised successor to the 3-bit state counter: a WIDTH-bit modulo-MODULO up/down counter.
- Adds clock enable, synchronous clear, parallel load, direction control, wrap or saturate mode, and terminal-count/wrap flags.
- Used as the generic state/sequence counter feeding FSM and datapath control in the homework designs.
- Built on a WIDTH-wide enable register bank, following the existing per-bit flip-flop structure.

---
 rtl/param_counter_pkg.sv | 10 +
 rtl/param_counter_reg_bank.sv | 16 +
 rtl/param_counter.sv | 48 ++++
 tb/tb_param_counter.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/param_counter_pkg.sv
// param_counter_pkg: direction and mode constants shared by the counter slice
`ifndef PC_DEFS_SV
`define PC_DEFS_SV
package pc_defs;
  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;
  localparam int   MODE_WRAP = 0;
  localparam int   MODE_SAT  = 1;
endpackage
`endif

// File: rtl/param_counter_reg_bank.sv
// reg_bank: WIDTH-wide enabled D register, one async-reset flop per bit
module reg_bank #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    always_ff @(posedge clk or posedge rst)
      if (rst) q[g] <= 1'b0;
      else if (en) q[g] <= d[g];
  end
endmodule

// File: rtl/param_counter.sv
// param_counter: WIDTH-bit modulo-MODULO up/down counter with load, clear, wrap/saturate
module param_counter
  import pc_defs::*;
#(
  parameter int WIDTH    = 3,
  parameter int MODULO   = 8,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             up,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);
  if (WIDTH < 1 || WIDTH > 16 || MODULO < 2 || MODULO > (1 << WIDTH)) begin : g_bad_cfg
    $error("param_counter: illegal WIDTH/MODULO combination");
  end
  // Range comparisons use WIDTH+1 bits so MODULO == 2**WIDTH does not alias to 0
  localparam logic [WIDTH:0]   L_MOD   = (WIDTH+1)'(MODULO);
  localparam logic [WIDTH:0]   L_MAX   = (WIDTH+1)'(MODULO - 1);
  localparam logic [WIDTH-1:0] L_MAX_Q = WIDTH'(MODULO - 1);
  localparam logic             L_WRAP  = SATURATE == MODE_WRAP;
  logic [WIDTH:0]   w_q_ext;
  logic [WIDTH-1:0] w_inc, w_dec, w_load, w_next;
  logic             w_top, w_bot, w_wrap_d;
  assign w_q_ext = {1'b0, q};
  assign w_top   = w_q_ext == L_MAX;
  assign w_bot   = q == '0;
  // Increment/decrement only happen away from the range ends, so WIDTH bits never overflow
  assign w_inc   = w_top ? (L_WRAP ? '0 : q) : q + 1'b1;
  assign w_dec   = w_bot ? (L_WRAP ? L_MAX_Q : q) : q - 1'b1;
  assign w_load  = ({1'b0, load_val} < L_MOD) ? load_val : L_MAX_Q;
  assign w_next  = clr ? '0 : load ? w_load : (up == DIR_UP) ? w_inc : w_dec;
  assign w_wrap_d = clk_en & ~clr & ~load & L_WRAP & ((up == DIR_UP) ? w_top : w_bot);
  assign tc      = (up == DIR_DOWN) ? w_bot : w_top;
  reg_bank #(.WIDTH(WIDTH)) u_q (
    .clk(clk), .rst(rst), .en(clk_en), .d(w_next), .q(q)
  );
  // wrap is a single-cycle pulse, so its flop loads every edge
  reg_bank #(.WIDTH(1)) u_wrap (
    .clk(clk), .rst(rst), .en(1'b1), .d(w_wrap_d), .q(wrap)
  );
endmodule

// File: tb/tb_param_counter.sv
// tb_param_counter: scoreboard bench over three counter configurations
module tb_param_counter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0, clr = 1'b0, ld = 1'b0, up = 1'b1;
  logic [15:0] lv = '0;
  int          checks = 0, failures = 0;
  event        ev_step, ev_rst;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", nm, got, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_c
    localparam int W = (g == 2) ? 4 : 3;
    localparam int M = (g == 2) ? 16 : 6;
    localparam int S = (g == 1) ? 1 : 0;
    logic [W-1:0] q;
    logic         tc, wrap;
    int           m_q = 0, m_cur = 0;
    int           exp_q[$];

    param_counter #(.WIDTH(W), .MODULO(M), .SATURATE(S)) dut (
      .clk(clk), .rst(rst), .clk_en(en), .clr(clr), .load(ld),
      .load_val(lv[W-1:0]), .up(up), .q(q), .tc(tc), .wrap(wrap)
    );

    // Reference: modulo arithmetic on plain integers
    always @(ev_step) begin
      int v, n;
      bit w;
      v = int'(lv[W-1:0]);
      n = m_q;
      w = 1'b0;
      if (en) begin
        if (clr) n = 0;
        else if (ld) n = (v < M) ? v : M - 1;
        else if (up) begin
          if (!(S == 1 && m_q == M - 1)) begin
            n = (m_q + 1) % M;
            w = (n == 0);
          end
        end else begin
          if (!(S == 1 && m_q == 0)) begin
            n = (m_q + M - 1) % M;
            w = (m_q == 0);
          end
        end
      end
      m_q = n;
      exp_q.push_back(n * 2 + int'(w));
    end

    always @(ev_rst) begin
      chk($sformatf("c%0d_async_rst_q", g), int'(q), 0);
      chk($sformatf("c%0d_async_rst_wrap", g), int'(wrap), 0);
      m_q = 0;
      m_cur = 0;
    end

    always begin
      @(posedge clk);
      #1;
      if (rst) begin
        chk($sformatf("c%0d_rst_q", g), int'(q), 0);
        chk($sformatf("c%0d_rst_wrap", g), int'(wrap), 0);
        m_cur = 0;
      end else if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL c%0d_sb_empty got=edge exp=no_edge t=%0t", g, $time);
      end else begin
        int e;
        e = exp_q.pop_front();
        m_cur = e / 2;
        chk($sformatf("c%0d_q", g), int'(q), m_cur);
        chk($sformatf("c%0d_wrap", g), int'(wrap), e % 2);
        chk($sformatf("c%0d_tc", g), int'(tc), int'(up ? (m_cur == M - 1) : (m_cur == 0)));
      end
    end

    // tc must follow an up change made mid-cycle
    always begin
      @(negedge clk);
      #1;
      if (!rst)
        chk($sformatf("c%0d_tc_mid", g), int'(tc), int'(up ? (m_cur == M - 1) : (m_cur == 0)));
    end
  end

  task automatic step(input bit e, input bit c, input bit l, input int v, input bit u);
    en = e; clr = c; ld = l; lv = 16'(v); up = u;
    -> ev_step;
    @(negedge clk);
  endtask

  task automatic do_rst();
    #2 rst = 1'b1;
    #1 -> ev_rst;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) step(1, 0, 0, 0, 1);
    step(1, 0, 1, 0, 1);
    repeat (3) step(1, 0, 0, 0, 0);
    step(1, 0, 1, 4, 1);
    repeat (4) step(1, 0, 0, 0, 1);
    repeat (2) step(1, 0, 0, 0, 0);
    step(1, 0, 1, 7, 1);
    step(1, 0, 1, 2, 1);
    step(1, 1, 1, 3, 1);
    step(1, 0, 1, 2, 1);
    step(1, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    do_rst();
    step(1, 0, 1, 14, 1);
    repeat (3) step(1, 0, 0, 0, 1);
    step(1, 0, 1, 15, 0);
    step(1, 0, 0, 0, 1);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) < 3) do_rst();
      else step($urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0,
                $urandom_range(0, 9) == 0, $urandom_range(0, 17), 1'($urandom_range(0, 1)));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
